spi_lcd_slave: RTL

- SPI-slave model of the LCD panel controller: the receiving end of the 4-wire link (SCLK, MOSI, CS, D/C) that the LCD init/draw logic drives through `spi_master`.
- Oversamples the serial link on the system clock and deserializes bytes.
- Decodes the MIPI-DCS subset the design uses (CASET/RASET/RAMWR/SLPOUT/SLPIN/DISPON/DISPOFF/SWRESET) and emits addressed RGB565 pixel writes.
- Used as a loopback checker in simulation and as a frame-capture front end on hardware.

---
 rtl/spi_lcd_slave_if.sv | 15 +
 rtl/spi_lcd_slave.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_lcd_slave_if.sv
// spi_lcd_slave_if: the 4-wire LCD link (SCLK, MOSI, CS, D/C).
//   sclk   : SPI clock, mode 0, asynchronous to the receiver's system clock
//   mosi   : serial data, MSB first
//   cs     : chip select, active-low
//   lcd_rs : D/C line, 0 = command byte, 1 = parameter/data byte
// The master modport drives the link; the slave modport only samples it.
interface spi_lcd_slave_if;
  logic sclk;
  logic mosi;
  logic cs;
  logic lcd_rs;

  modport master (output sclk, mosi, cs, lcd_rs);
  modport slave  (input  sclk, mosi, cs, lcd_rs);
endinterface

// File: rtl/spi_lcd_slave.sv
// spi_lcd_slave: receiving end of the LCD SPI link. Oversamples the link on
// clk, deserializes bytes, decodes the DCS subset (CASET/RASET/RAMWR/SLPOUT/
// SLPIN/DISPON/DISPOFF/SWRESET) and emits addressed RGB565 pixel writes.
// Ports:
//   clk, reset_n       : system clock, async active-low reset
//   spi                : link inputs (slave modport)
//   byte_valid/_data/_is_data : one-cycle strobe per received byte, with D/C
//   cmd_valid/cmd_code : strobe per command byte, last command code
//   pixel_valid/_x/_y/_data   : strobe per complete pixel with its address
//   frame_done         : strobe with the pixel at (XE,YE)
//   sleeping, display_on      : panel state
//   param_err          : sticky, set when a CASET/RASET window is rejected
module spi_lcd_slave #(
  parameter int X_W     = 9,
  parameter int Y_W     = 9,
  parameter int MAX_COL = 239,
  parameter int MAX_ROW = 319
) (
  input  logic           clk,
  input  logic           reset_n,
  spi_lcd_slave_if.slave spi,
  output logic           byte_valid,
  output logic [7:0]     byte_data,
  output logic           byte_is_data,
  output logic           cmd_valid,
  output logic [7:0]     cmd_code,
  output logic           pixel_valid,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic [15:0]    pixel_data,
  output logic           frame_done,
  output logic           sleeping,
  output logic           display_on,
  output logic           param_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_CASET, ST_RASET, ST_RAMWR, ST_IGNORE} state_e;

  // Front end
  logic [1:0] sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d;
  logic [1:0] cs_sync_q, cs_sync_d, rs_sync_q, rs_sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_valid_q, byte_valid_d, byte_is_data_q, byte_is_data_d;
  logic [7:0] byte_data_q, byte_data_d;
  // Decoder
  state_e         state_q, state_d;
  logic [1:0]     param_cnt_q, param_cnt_d;
  logic [23:0]    params_q, params_d;
  logic [X_W-1:0] xs_q, xs_d, xe_q, xe_d, x_q, x_d, pix_x_q, pix_x_d;
  logic [Y_W-1:0] ys_q, ys_d, ye_q, ye_d, y_q, y_d, pix_y_q, pix_y_d;
  logic           phase_lo_q, phase_lo_d;
  logic [7:0]     pix_hi_q, pix_hi_d, cmd_code_q, cmd_code_d;
  logic [15:0]    pix_data_q, pix_data_d;
  logic           cmd_valid_q, cmd_valid_d, pixel_valid_q, pixel_valid_d;
  logic           frame_done_q, frame_done_d;
  logic           sleeping_q, sleeping_d, display_on_q, display_on_d;
  logic           param_err_q, param_err_d;

  logic        sclk_rise;
  logic [15:0] win_start, win_end;

  always_comb begin
    sclk_sync_d    = {sclk_sync_q[0], spi.sclk};
    mosi_sync_d    = {mosi_sync_q[0], spi.mosi};
    cs_sync_d      = {cs_sync_q[0], spi.cs};
    rs_sync_d      = {rs_sync_q[0], spi.lcd_rs};
    sclk_prev_d    = sclk_sync_q[1];
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    byte_valid_d   = 1'b0;
    byte_data_d    = byte_data_q;
    byte_is_data_d = byte_is_data_q;
    state_d        = state_q;
    param_cnt_d    = param_cnt_q;
    params_d       = params_q;
    xs_d           = xs_q;
    xe_d           = xe_q;
    ys_d           = ys_q;
    ye_d           = ye_q;
    x_d            = x_q;
    y_d            = y_q;
    pix_x_d        = pix_x_q;
    pix_y_d        = pix_y_q;
    phase_lo_d     = phase_lo_q;
    pix_hi_d       = pix_hi_q;
    pix_data_d     = pix_data_q;
    cmd_code_d     = cmd_code_q;
    cmd_valid_d    = 1'b0;
    pixel_valid_d  = 1'b0;
    frame_done_d   = 1'b0;
    sleeping_d     = sleeping_q;
    display_on_d   = display_on_q;
    param_err_d    = param_err_q;

    sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    // The 4th param byte completes the 16-bit end coordinate.
    win_start = params_q[23:8];
    win_end   = {params_q[7:0], byte_data_q};

    // Deserializer: a deasserted CS drops any partial byte.
    if (cs_sync_q[1]) begin
      bit_cnt_d = 3'd0;
    end else if (sclk_rise) begin
      shift_d   = {shift_q[6:0], mosi_sync_q[1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_valid_d   = 1'b1;
        byte_data_d    = {shift_q[6:0], mosi_sync_q[1]};
        byte_is_data_d = rs_sync_q[1];
      end
    end

    // Decoder works on the registered byte, hence one cycle behind byte_valid.
    if (byte_valid_q) begin
      if (!byte_is_data_q) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = byte_data_q;
        param_cnt_d = 2'd0;
        phase_lo_d  = 1'b0;
        state_d     = ST_IGNORE;
        case (byte_data_q)
          8'h2A: state_d = ST_CASET;
          8'h2B: state_d = ST_RASET;
          8'h2C: begin
            state_d = ST_RAMWR;
            x_d     = xs_q;
            y_d     = ys_q;
          end
          8'h11: sleeping_d   = 1'b0;
          8'h10: sleeping_d   = 1'b1;
          8'h29: display_on_d = 1'b1;
          8'h28: display_on_d = 1'b0;
          8'h01: begin
            xs_d         = '0;
            xe_d         = X_W'(MAX_COL);
            ys_d         = '0;
            ye_d         = Y_W'(MAX_ROW);
            sleeping_d   = 1'b1;
            display_on_d = 1'b0;
            param_err_d  = 1'b0;
            state_d      = ST_IDLE;
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          ST_CASET, ST_RASET: begin
            if (param_cnt_q != 2'd3) begin
              params_d    = {params_q[15:0], byte_data_q};
              param_cnt_d = param_cnt_q + 2'd1;
            end else begin
              param_cnt_d = 2'd0;
              state_d     = ST_IGNORE;
              if (state_q == ST_CASET) begin
                if (win_start > win_end || win_end > 16'(MAX_COL)) begin
                  param_err_d = 1'b1;
                end else begin
                  xs_d = win_start[X_W-1:0];
                  xe_d = win_end[X_W-1:0];
                end
              end else begin
                if (win_start > win_end || win_end > 16'(MAX_ROW)) begin
                  param_err_d = 1'b1;
                end else begin
                  ys_d = win_start[Y_W-1:0];
                  ye_d = win_end[Y_W-1:0];
                end
              end
            end
          end
          ST_RAMWR: begin
            if (!phase_lo_q) begin
              pix_hi_d   = byte_data_q;
              phase_lo_d = 1'b1;
            end else begin
              phase_lo_d    = 1'b0;
              pixel_valid_d = 1'b1;
              pix_x_d       = x_q;
              pix_y_d       = y_q;
              pix_data_d    = {pix_hi_q, byte_data_q};
              // Raster scan inside the window, wrapping to (XS,YS).
              if (x_q != xe_q) begin
                x_d = x_q + X_W'(1);
              end else begin
                x_d = xs_q;
                if (y_q != ye_q) begin
                  y_d = y_q + Y_W'(1);
                end else begin
                  y_d          = ys_q;
                  frame_done_d = 1'b1;
                end
              end
            end
          end
          default: ; // data in IDLE/IGNORE is dropped
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q    <= '0;
      mosi_sync_q    <= '0;
      cs_sync_q      <= 2'b11;
      rs_sync_q      <= '0;
      sclk_prev_q    <= 1'b0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= '0;
      byte_is_data_q <= 1'b0;
      state_q        <= ST_IDLE;
      param_cnt_q    <= '0;
      params_q       <= '0;
      xs_q           <= '0;
      xe_q           <= X_W'(MAX_COL);
      ys_q           <= '0;
      ye_q           <= Y_W'(MAX_ROW);
      x_q            <= '0;
      y_q            <= '0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      phase_lo_q     <= 1'b0;
      pix_hi_q       <= '0;
      pix_data_q     <= '0;
      cmd_code_q     <= '0;
      cmd_valid_q    <= 1'b0;
      pixel_valid_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      sleeping_q     <= 1'b1;
      display_on_q   <= 1'b0;
      param_err_q    <= 1'b0;
    end else begin
      sclk_sync_q    <= sclk_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      cs_sync_q      <= cs_sync_d;
      rs_sync_q      <= rs_sync_d;
      sclk_prev_q    <= sclk_prev_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      byte_is_data_q <= byte_is_data_d;
      state_q        <= state_d;
      param_cnt_q    <= param_cnt_d;
      params_q       <= params_d;
      xs_q           <= xs_d;
      xe_q           <= xe_d;
      ys_q           <= ys_d;
      ye_q           <= ye_d;
      x_q            <= x_d;
      y_q            <= y_d;
      pix_x_q        <= pix_x_d;
      pix_y_q        <= pix_y_d;
      phase_lo_q     <= phase_lo_d;
      pix_hi_q       <= pix_hi_d;
      pix_data_q     <= pix_data_d;
      cmd_code_q     <= cmd_code_d;
      cmd_valid_q    <= cmd_valid_d;
      pixel_valid_q  <= pixel_valid_d;
      frame_done_q   <= frame_done_d;
      sleeping_q     <= sleeping_d;
      display_on_q   <= display_on_d;
      param_err_q    <= param_err_d;
    end
  end

  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign byte_is_data = byte_is_data_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_code     = cmd_code_q;
  assign pixel_valid  = pixel_valid_q;
  assign pixel_x      = pix_x_q;
  assign pixel_y      = pix_y_q;
  assign pixel_data   = pix_data_q;
  assign frame_done   = frame_done_q;
  assign sleeping     = sleeping_q;
  assign display_on   = display_on_q;
  assign param_err    = param_err_q;

endmodule
